// File: rtl/btn_event_buffer_if.sv
// Memory-mapped bus bundle between the SoC master and the button event buffer.
// Single-cycle request pulse, registered one-cycle completion with read data.
interface btn_event_buffer_if;
  logic        bus_en;
  logic        bus_we;
  logic [3:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  modport master (
    output bus_en, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_en, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );
endinterface

// File: rtl/btn_event_buffer.sv
// Push-button responder: synchronises and debounces active-low pins, queues one
// event per accepted press, and exposes STATUS/EVENT/CTRL registers on the bus.
module btn_event_buffer #(
  parameter int NUM_BTNS        = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_BTNS-1:0] btn_n,
  btn_event_buffer_if.slave   bus,
  output logic                irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] ADDR_STATUS = 4'h0;
  localparam logic [3:0] ADDR_EVENT  = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  logic [NUM_BTNS-1:0] r_sync1;
  logic [NUM_BTNS-1:0] r_sync2;
  logic [CW-1:0]       r_cnt [NUM_BTNS];
  logic [NUM_BTNS-1:0] r_stable;
  logic [NUM_BTNS-1:0] r_pend;
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_wptr;
  logic [PW-1:0]       r_rptr;
  logic                r_ovf;
  logic                r_irq_en;
  logic                r_ready;
  logic [31:0]         r_rdata;

  logic [NUM_BTNS-1:0] w_pressed;
  logic [NUM_BTNS-1:0] w_accept;
  logic [NUM_BTNS-1:0] w_rise;
  logic [NUM_BTNS-1:0] w_sel_oh;
  logic [7:0]          w_sel_idx;
  logic                w_empty;
  logic                w_full;
  logic [PW-1:0]       w_occ;
  logic                w_bus_acc;
  logic                w_pop;
  logic                w_enq;
  logic                w_push;
  logic                w_drop;
  logic                w_ctrl_wr;
  logic                w_flush;
  logic [31:0]         w_status;
  logic [31:0]         w_rdata;
  logic                w_unused;

  assign w_pressed = ~r_sync2;

  // A level is accepted on the edge where it has differed from the stable
  // value for DEBOUNCE_CYCLES consecutive synced samples.
  always_comb begin
    w_accept = '0;
    for (int unsigned i = 0; i < NUM_BTNS; i++) begin
      w_accept[i] = (w_pressed[i] != r_stable[i]) && (r_cnt[i] == CNT_LAST);
    end
  end

  assign w_rise = w_accept & w_pressed;

  // Descending scan so the lowest pending index is the last one written.
  always_comb begin
    w_sel_oh  = '0;
    w_sel_idx = '0;
    for (int unsigned i = NUM_BTNS; i > 0; i--) begin
      if (r_pend[i-1]) begin
        w_sel_oh  = NUM_BTNS'(1) << (i - 1);
        w_sel_idx = 8'(i - 1);
      end
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_occ   = r_wptr - r_rptr;

  assign w_bus_acc = bus.bus_en && !r_ready;
  assign w_pop     = w_bus_acc && !bus.bus_we && (bus.bus_addr == ADDR_EVENT) && !w_empty;
  assign w_ctrl_wr = w_bus_acc && bus.bus_we && (bus.bus_addr == ADDR_CTRL);
  assign w_flush   = w_ctrl_wr && bus.bus_wdata[1];
  assign w_enq     = |r_pend;
  assign w_push    = w_enq && (!w_full || w_pop) && !w_flush;
  assign w_drop    = w_enq && w_full && !w_pop;

  always_comb begin
    w_status                 = '0;
    w_status[NUM_BTNS-1:0]   = r_stable;
    w_status[8]              = w_empty;
    w_status[9]              = w_full;
    w_status[10]             = r_ovf;
    w_status[14:12]          = 3'(w_occ);
  end

  always_comb begin
    w_rdata = '0;
    if (!bus.bus_we) begin
      case (bus.bus_addr)
        ADDR_STATUS: w_rdata = w_status;
        ADDR_EVENT:  if (!w_empty) w_rdata = {1'b1, 23'b0, r_mem[r_rptr[AW-1:0]]};
        ADDR_CTRL:   w_rdata = {31'b0, r_irq_en};
        default:     w_rdata = '0;
      endcase
    end
  end

  assign w_unused = ^bus.bus_wdata[31:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= '1;
      r_sync2  <= '1;
      r_stable <= '0;
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1 <= btn_n;
      r_sync2 <= r_sync1;
      for (int unsigned i = 0; i < NUM_BTNS; i++) begin
        if (w_pressed[i] != r_stable[i]) begin
          if (w_accept[i]) begin
            r_stable[i] <= w_pressed[i];
            r_cnt[i]    <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + 1'b1;
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  // Flush takes precedence over any enqueue, drop or new press on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else if (w_flush) begin
      r_pend <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_ovf  <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_sel_oh) | w_rise;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_drop) r_ovf  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= w_sel_idx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq_en <= 1'b0;
      r_ready  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= bus.bus_wdata[0];
      r_ready <= w_bus_acc;
      r_rdata <= w_bus_acc ? w_rdata : '0;
    end
  end

  assign bus.bus_ready = r_ready;
  assign bus.bus_rdata = r_rdata;
  assign irq           = r_irq_en && !w_empty;

endmodule
